// File: rtl/spi_temp_pkg.sv
// Shared definitions for the SPI temperature slave.
//
// Contents:
//   state_t          - frame FSM states (IDLE, ADDR, DATA, PAR, DONE)
//   DEF_DATA_W       - default temperature word width
//   DEF_NUM_CH       - default number of sensor channels
//   DEF_RESET_TEMP   - default reset value of every channel register
//   ch_width()       - channel address width, never less than one bit
//
// PAR is only reachable when SPI_TEMP_PARITY_EN is defined.
package spi_temp_pkg;

    localparam int          DEF_DATA_W     = 16;
    localparam int          DEF_NUM_CH     = 4;
    localparam logic [15:0] DEF_RESET_TEMP = 16'h3100;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        DONE = 3'd4
    } state_t;

    // A single channel still needs one address bit on the wire.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input.
//
// Parameters:
//   RESET_VAL - value both flops take during reset (the idle level of the input)
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output, two clocks of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_temp_slave.sv
// SPI read-only temperature slave.
//
// The master lowers CS, shifts a CH_W-bit channel address in on SI (sampled on
// SCK rise, MSB first) and then reads the DATA_W-bit channel word on SO, MSB
// first. SO moves to the next bit on each SCK fall, so the master samples SO
// while SCK is high. The address's last rising edge loads the word, so the
// first data bit is already valid during that same high phase.
//
// Optional feature: define SPI_TEMP_PARITY_EN to append an even-parity bit
// (XOR of the word) after the data bits.
//
// Ports:
//   CLK, RST_N          - system clock, asynchronous active-low reset
//   CS, SCK, SI         - SPI inputs, asynchronous to CLK (SCK <= CLK/8)
//   SO, SO_OE           - serial data out and its tristate enable
//   TEMP_WE/CH/IN       - synchronous channel-register write port
//   BUSY                - frame in progress (state not IDLE)
//   ADDR_ERR            - one-CLK pulse when the address is >= NUM_CH
module spi_temp_slave
    import spi_temp_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                NUM_CH     = DEF_NUM_CH,
    parameter logic [DATA_W-1:0] RESET_TEMP = DATA_W'(DEF_RESET_TEMP),
    localparam int               CH_W       = ch_width(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS,
    input  logic              SCK,
    input  logic              SI,
    output logic              SO,
    output logic              SO_OE,
    input  logic              TEMP_WE,
    input  logic [CH_W-1:0]   TEMP_CH,
    input  logic [DATA_W-1:0] TEMP_IN,
    output logic              BUSY,
    output logic              ADDR_ERR
);

    localparam int MAX_W = (DATA_W > CH_W) ? DATA_W : CH_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    logic cs_s, sck_s, si_s;
    logic cs_d, sck_d;
    logic cs_fall, cs_rise, sck_rise, sck_fall;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              addr_err_q, addr_err_d;

    logic [DATA_W-1:0] regs [NUM_CH];
    logic [CH_W:0]     addr_ext;
    logic [CH_W-1:0]   addr_full;
    logic              addr_ok;
    logic [DATA_W-1:0] load_word;

`ifdef SPI_TEMP_PARITY_EN
    logic par_q, par_d;
`endif

    // Inputs idle at CS high, SCK low, SI low so that reset looks like "no frame".
    sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs  (.clk(CLK), .rst_n(RST_N), .d(CS),  .q(cs_s));
    sync_2ff #(.RESET_VAL(1'b0)) u_sync_sck (.clk(CLK), .rst_n(RST_N), .d(SCK), .q(sck_s));
    sync_2ff #(.RESET_VAL(1'b0)) u_sync_si  (.clk(CLK), .rst_n(RST_N), .d(SI),  .q(si_s));

    // Previous synchronised levels for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_d  <= 1'b1;
            sck_d <= 1'b0;
        end else begin
            cs_d  <= cs_s;
            sck_d <= sck_s;
        end
    end

    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    // Channel registers. Out-of-range writes are dropped. A write landing on
    // the same edge as a frame load does not reach that frame, because the
    // load below reads the register before this edge updates it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                regs[i] <= RESET_TEMP;
            end
        end else if (TEMP_WE && (int'(TEMP_CH) < NUM_CH)) begin
            regs[TEMP_CH] <= TEMP_IN;
        end
    end

    // Address including the bit arriving on the current SCK rise; used so the
    // word can be loaded on the same edge that completes the address.
    assign addr_ext  = {addr_q, si_s};
    assign addr_full = addr_ext[CH_W-1:0];
    assign addr_ok   = (int'(addr_full) < NUM_CH);
    assign load_word = addr_ok ? regs[addr_full] : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            addr_err_q <= 1'b0;
`ifdef SPI_TEMP_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            addr_err_q <= addr_err_d;
`ifdef SPI_TEMP_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Frame sequencing. A CS rise wins over everything and abandons the frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        addr_err_d = 1'b0;
`ifdef SPI_TEMP_PARITY_EN
        par_d      = par_q;
`endif
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                        addr_d  = '0;
                        shift_d = '0;
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_d = addr_full;
                        if (cnt_q == CNT_W'(CH_W - 1)) begin
                            state_d    = DATA;
                            cnt_d      = '0;
                            shift_d    = load_word;
                            addr_err_d = ~addr_ok;
`ifdef SPI_TEMP_PARITY_EN
                            par_d      = ^load_word;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d = '0;
`ifdef SPI_TEMP_PARITY_EN
                            state_d = PAR;
`else
                            state_d = DONE;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`ifdef SPI_TEMP_PARITY_EN
                PAR: begin
                    if (sck_fall) begin
                        state_d = DONE;
                    end
                end
`endif
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    always_comb begin
        SO    = 1'b0;
        SO_OE = 1'b0;
        case (state_q)
            DATA: begin
                SO    = shift_q[DATA_W-1];
                SO_OE = 1'b1;
            end
`ifdef SPI_TEMP_PARITY_EN
            PAR: begin
                SO    = par_q;
                SO_OE = 1'b1;
            end
`endif
            DONE: begin
                SO_OE = 1'b1;
            end
            default: begin
                SO    = 1'b0;
                SO_OE = 1'b0;
            end
        endcase
    end

    assign BUSY     = (state_q != IDLE);
    assign ADDR_ERR = addr_err_q;

endmodule
